// File: rtl/mram_serial_host.sv
// mram_serial_host: host-side initiator for the MRAM top-level serial link.
// Frames a parallel read/write request onto link_rst/ser_addr/ser_data/ser_rw,
// sending both address and data LSB first. For reads, it deserialises ser_din back
// into a parallel word.
// Optional feature macro: MRAM_HOST_STATS_EN enables saturating write/read
// completion counters. Without it, wr_count/rd_count read as zero.
module mram_serial_host #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int READ_LAT    = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              link_rst,
  output logic              ser_addr,
  output logic              ser_data,
  output logic              ser_rw,
  input  logic              ser_din,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_WR_HOLD = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_CAPT = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_sh_q;   // address bits still to be sent, next bit at [0]
  logic [DATA_W-1:0]   wdata_sh_q;  // write bits still to be sent; zero for reads
  logic [DATA_W-2:0]   cap_sh_q;    // read bits captured so far, oldest at [0]
  logic [DATA_W-1:0]   rd_data_q;
  logic                req_ready_q;
  logic                link_rst_q;
  logic                ser_addr_q;
  logic                ser_data_q;
  logic                ser_rw_q;
  logic                rd_valid_q;
  logic                wr_done_q;

  // Frame sequencer: state, phase counter, shift registers and all link/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      cap_sh_q    <= '0;
      rd_data_q   <= '0;
      req_ready_q <= 1'b0;
      link_rst_q  <= 1'b1;
      ser_addr_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_rw_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= S_SHIFT;
            cnt_q       <= '0;
            rw_q        <= req_rw;
            req_ready_q <= 1'b0;
            link_rst_q  <= 1'b0;
            ser_rw_q    <= req_rw;
            ser_addr_q  <= req_addr[0];
            addr_sh_q   <= {1'b0, req_addr[ADDR_W-1:1]};
            if (req_rw) begin
              ser_data_q <= req_wdata[0];
              wdata_sh_q <= {1'b0, req_wdata[DATA_W-1:1]};
            end else begin
              ser_data_q <= 1'b0;
              wdata_sh_q <= '0;
            end
          end else begin
            req_ready_q <= 1'b1;
            link_rst_q  <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt_q == SHIFT_LAST) begin
            ser_addr_q <= 1'b0;
            ser_data_q <= 1'b0;
            cnt_q      <= '0;
            if (rw_q) begin
              if (HOLD_CYCLES == 0) begin
                state_q    <= S_GAP;
                link_rst_q <= 1'b1;
                ser_rw_q   <= 1'b0;
                wr_done_q  <= 1'b1;
              end else begin
                state_q <= S_WR_HOLD;
              end
            end else begin
              if (READ_LAT == 0) begin
                state_q <= S_RD_CAPT;
              end else begin
                state_q <= S_RD_WAIT;
              end
            end
          end else begin
            // Zeros shift into wdata_sh_q, so bits at and above DATA_W go out as 0.
            ser_addr_q <= addr_sh_q[0];
            addr_sh_q  <= {1'b0, addr_sh_q[ADDR_W-1:1]};
            ser_data_q <= wdata_sh_q[0];
            wdata_sh_q <= {1'b0, wdata_sh_q[DATA_W-1:1]};
            cnt_q      <= cnt_q + CNT_ONE;
          end
        end

        S_WR_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q    <= S_GAP;
            cnt_q      <= '0;
            link_rst_q <= 1'b1;
            ser_rw_q   <= 1'b0;
            wr_done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_RD_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= S_RD_CAPT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_RD_CAPT: begin
          // New bit enters at the top; after DATA_W samples, bit i holds capture cycle i.
          cap_sh_q <= {ser_din, cap_sh_q[DATA_W-2:1]};
          if (cnt_q == CAPT_LAST) begin
            state_q    <= S_GAP;
            cnt_q      <= '0;
            link_rst_q <= 1'b1;
            ser_rw_q   <= 1'b0;
            rd_data_q  <= {ser_din, cap_sh_q};
            rd_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          req_ready_q <= 1'b0;
          link_rst_q  <= 1'b1;
          ser_addr_q  <= 1'b0;
          ser_data_q  <= 1'b0;
          ser_rw_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign link_rst  = link_rst_q;
  assign ser_addr  = ser_addr_q;
  assign ser_data  = ser_data_q;
  assign ser_rw    = ser_rw_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_done   = wr_done_q;

`ifdef MRAM_HOST_STATS_EN
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;
  logic [15:0] rd_count_q;
  logic [15:0] rd_count_d;

  // Next counter values: step once per completion pulse, saturating at all-ones.
  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (wr_done_q && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    if (rd_valid_q && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
  end

  // Completion counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_count_q <= 16'd0;
      rd_count_q <= 16'd0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`else
  assign wr_count = 16'h0000;
  assign rd_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mram_serial_host.sv
// Directed, table-driven bench for mram_serial_host with a small link model on ser_din.
module tb_mram_serial_host;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_done;
  logic        link_rst;
  logic        ser_addr;
  logic        ser_data;
  logic        ser_rw;
  logic        ser_din;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  mram_serial_host dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done),
    .link_rst(link_rst), .ser_addr(ser_addr), .ser_data(ser_data), .ser_rw(ser_rw),
    .ser_din(ser_din), .wr_count(wr_count), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] link_rdata;
    logic [19:0] exp_sa;
    logic [19:0] exp_sd;
    int          exp_low;
    int          exp_wrd;
    int          exp_rdv;
    logic [15:0] exp_rd_data;
  } vec_t;

  vec_t vecs [5];

  int n_cmp = 0;
  int n_err = 0;

  // observation results of the most recent frame
  int          obs_low;
  logic [19:0] obs_sa;
  logic [19:0] obs_sd;
  int          obs_badrw;
  int          obs_junk;
  int          obs_wrd;
  int          obs_rdv;
  int          obs_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for req_ready (bounded), then present one request for exactly one accept edge.
  task automatic start_txn(input logic rw, input logic [19:0] a, input logic [15:0] d);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Called in frame cycle 0; follows the frame to the next IDLE, playing the link side.
  task automatic observe(input logic rw, input logic [15:0] rdata, input int pulse_at);
    obs_low = 0; obs_sa = '0; obs_sd = '0; obs_badrw = 0; obs_junk = 0;
    obs_wrd = 0; obs_rdv = 0; obs_done = 0;
    for (int c = 0; c < 300 && obs_done == 0; c++) begin
      if (!link_rst) begin
        if (obs_low < 20) begin
          obs_sa[obs_low] = ser_addr;
          obs_sd[obs_low] = ser_data;
        end else if (ser_addr || ser_data) begin
          obs_junk++;
        end
        if (ser_rw !== rw) obs_badrw++;
        if (req_ready) obs_junk++;
        if (wr_done || rd_valid) obs_junk++;
        if (obs_low >= 22 && obs_low < 38) ser_din = rdata[obs_low-22];
        else ser_din = 1'b0;
        req_valid = (obs_low == pulse_at);
        if (obs_low == pulse_at) req_rw = 1'b1;
        obs_low++;
      end else begin
        ser_din   = 1'b0;
        req_valid = 1'b0;
        if (ser_rw || ser_addr || ser_data) obs_junk++;
        if (wr_done) obs_wrd++;
        if (rd_valid) obs_rdv++;
        if (req_ready) obs_done = 1;
      end
      if (obs_done == 0) tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wd_cyc;
    int high_cnt;
    int found;
    int cyc;
    int lows;
    int pulses;
    logic [15:0] exp_w;
    logic [15:0] exp_r;

    vecs[0] = '{1'b1, 20'h00000, 16'h03FF, 16'h0000, 20'h00000, 20'h003FF, 22, 1, 0, 16'h0000};
    vecs[1] = '{1'b0, 20'h00005, 16'hBEEF, 16'hA5C3, 20'h00005, 20'h00000, 38, 0, 1, 16'hA5C3};
    vecs[2] = '{1'b1, 20'hABCDE, 16'h1234, 16'h0000, 20'hABCDE, 20'h01234, 22, 1, 0, 16'hA5C3};
    vecs[3] = '{1'b0, 20'hFFFFF, 16'h0000, 16'h0001, 20'hFFFFF, 20'h00000, 38, 0, 1, 16'h0001};
    vecs[4] = '{1'b1, 20'h80001, 16'hFFFF, 16'h0000, 20'h80001, 20'h0FFFF, 22, 1, 0, 16'h0001};

    rst = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; ser_din = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_link_rst",  {31'd0, link_rst},  32'd1);
    check("rst_ser_lines", {29'd0, ser_addr, ser_data, ser_rw}, 32'd0);
    check("rst_pulses",    {30'd0, rd_valid, wr_done}, 32'd0);
    check("rst_rd_data",   {16'd0, rd_data}, 32'd0);
    check("rst_counters",  {wr_count, rd_count}, 32'd0);
    rst = 1'b1;
    tick();
    check("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Table of single transactions
    for (int v = 0; v < 5; v++) begin
      start_txn(vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      observe(vecs[v].rw, vecs[v].link_rdata, -1);
      check($sformatf("v%0d_done", v),    obs_done, 1);
      check($sformatf("v%0d_low", v),     obs_low, vecs[v].exp_low);
      check($sformatf("v%0d_ser_addr", v), {12'd0, obs_sa}, {12'd0, vecs[v].exp_sa});
      check($sformatf("v%0d_ser_data", v), {12'd0, obs_sd}, {12'd0, vecs[v].exp_sd});
      check($sformatf("v%0d_ser_rw", v),  obs_badrw, 0);
      check($sformatf("v%0d_junk", v),    obs_junk, 0);
      check($sformatf("v%0d_wr_done", v), obs_wrd, vecs[v].exp_wrd);
      check($sformatf("v%0d_rd_valid", v), obs_rdv, vecs[v].exp_rdv);
      check($sformatf("v%0d_rd_data", v), {16'd0, rd_data}, {16'd0, vecs[v].exp_rd_data});
    end

`ifdef MRAM_HOST_STATS_EN
    exp_w = 16'd3; exp_r = 16'd2;
`else
    exp_w = 16'd0; exp_r = 16'd0;
`endif
    check("wr_count_3w2r", {16'd0, wr_count}, {16'd0, exp_w});
    check("rd_count_3w2r", {16'd0, rd_count}, {16'd0, exp_r});

    // Back-to-back: write then read with req_valid held high
    start_txn(1'b1, 20'h00010, 16'h0055);
    req_rw = 1'b0; req_addr = 20'h00003; req_valid = 1'b1;
    wd_cyc = -100; high_cnt = 0; found = 0; cyc = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (wr_done) wd_cyc = cyc;
      if (link_rst) high_cnt++;
      else if (high_cnt > 0) found = 1;
      if (found == 0) begin
        tick();
        cyc++;
      end
    end
    req_valid = 1'b0;
    check("b2b_second_frame", found, 1);
    check("b2b_accept_spacing", cyc - wd_cyc, 3);
    check("b2b_link_high_gap", high_cnt, 3);
    observe(1'b0, 16'h5A0F, -1);
    check("b2b_rd_low", obs_low, 38);
    check("b2b_rd_addr", {12'd0, obs_sa}, 32'h00003);
    check("b2b_rd_valid", obs_rdv, 1);
    check("b2b_rd_data", {16'd0, rd_data}, 32'h5A0F);

    // req_valid pulsed during RD_CAPT is ignored
    start_txn(1'b0, 20'h00007, 16'h0000);
    observe(1'b0, 16'h1111, 30);
    check("capt_pulse_low", obs_low, 38);
    check("capt_pulse_junk", obs_junk, 0);
    check("capt_pulse_rd_valid", obs_rdv, 1);
    check("capt_pulse_rd_data", {16'd0, rd_data}, 32'h1111);
    lows = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (!link_rst) lows++;
    end
    check("capt_pulse_no_extra_frame", lows, 0);

    // Reset during SHIFT cycle 7 of a read
    start_txn(1'b0, 20'h00005, 16'h0000);
    for (int c = 0; c < 7; c++) tick();
    check("mid_rst_in_frame", {31'd0, link_rst}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_link_rst", {31'd0, link_rst}, 32'd1);
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    lows = 0; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (!link_rst) lows++;
      if (rd_valid || wr_done) pulses++;
      tick();
    end
    check("post_rst_no_frame", lows, 0);
    check("post_rst_no_pulse", pulses, 0);
    start_txn(vecs[0].rw, vecs[0].addr, vecs[0].wdata);
    observe(vecs[0].rw, 16'h0000, -1);
    check("post_rst_wr_low", obs_low, 22);
    check("post_rst_wr_data", {12'd0, obs_sd}, 32'h003FF);
    check("post_rst_wr_done", obs_wrd, 1);
    check("post_rst_junk", obs_junk, 0);
`ifdef MRAM_HOST_STATS_EN
    exp_w = 16'd1; exp_r = 16'd0;
`else
    exp_w = 16'd0; exp_r = 16'd0;
`endif
    check("post_rst_wr_count", {16'd0, wr_count}, {16'd0, exp_w});
    check("post_rst_rd_count", {16'd0, rd_count}, {16'd0, exp_r});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
